// File: rtl/hdu_x1.sv
// Read-after-write hazard detector: stalls a read whose address matches a write from this cycle or the last HAZ_DEPTH cycles.
// Optional macro HDU_BANK_MATCH_EN narrows the match to the bank field addr[Bank_Num_W-1:0].
module hdu_x1 #(
    parameter int ADDR_W     = 16,
    parameter int Bank_Num_W = 5,
    parameter int HAZ_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] Raddr0,
    input  logic [ADDR_W-1:0] Waddr0,
    input  logic              Raddr_valid0,
    input  logic              Waddr_valid0,
    output logic              stall_signal
);

    localparam logic [ADDR_W-1:0] BANK_MASK = (ADDR_W'(1) << Bank_Num_W) - ADDR_W'(1);
`ifdef HDU_BANK_MATCH_EN
    localparam logic [ADDR_W-1:0] CMP_MASK = BANK_MASK;
`else
    localparam logic [ADDR_W-1:0] CMP_MASK = BANK_MASK | ~BANK_MASK;
`endif

    logic [HAZ_DEPTH-1:0] hist_valid_reg;
    logic [ADDR_W-1:0]    hist_addr_reg [HAZ_DEPTH];
    logic [HAZ_DEPTH-1:0] hist_match;
    logic                 cur_match;
    logic                 stall_reg;
    logic                 stall_next;

    // Addresses shift without reset; their valid bits alone gate matching.
    genvar gi;
    generate
        for (gi = 0; gi < HAZ_DEPTH; gi++) begin : g_hist
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (!rst) begin
                        hist_valid_reg[gi] <= 1'b0;
                    end else begin
                        hist_valid_reg[gi] <= Waddr_valid0;
                    end
                    hist_addr_reg[gi] <= Waddr0;
                end
            end else begin : g_tail
                always_ff @(posedge clk) begin
                    if (!rst) begin
                        hist_valid_reg[gi] <= 1'b0;
                    end else begin
                        hist_valid_reg[gi] <= hist_valid_reg[gi-1];
                    end
                    hist_addr_reg[gi] <= hist_addr_reg[gi-1];
                end
            end

            assign hist_match[gi] = hist_valid_reg[gi] &&
                                    (((hist_addr_reg[gi] ^ Raddr0) & CMP_MASK) == '0);
        end
    endgenerate

    assign cur_match = Waddr_valid0 && (((Waddr0 ^ Raddr0) & CMP_MASK) == '0);

    always_comb begin
        stall_next = Raddr_valid0 && (cur_match || (|hist_match));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_reg <= 1'b0;
        end else begin
            stall_reg <= stall_next;
        end
    end

    assign stall_signal = stall_reg;

endmodule

// File: tb/tb_hdu_x1.sv
// Randomized + directed bench for hdu_x1 with a queue-based scoreboard and a write-log reference model.
// Honors HDU_BANK_MATCH_EN in the reference comparison.
module tb_hdu_x1;

    localparam int ADDR_W     = 16;
    localparam int Bank_Num_W = 5;
    localparam int HAZ_DEPTH  = 4;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] Raddr0;
    logic [ADDR_W-1:0] Waddr0;
    logic              Raddr_valid0;
    logic              Waddr_valid0;
    logic              stall_signal;

    hdu_x1 #(
        .ADDR_W    (ADDR_W),
        .Bank_Num_W(Bank_Num_W),
        .HAZ_DEPTH (HAZ_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .Raddr0      (Raddr0),
        .Waddr0      (Waddr0),
        .Raddr_valid0(Raddr_valid0),
        .Waddr_valid0(Waddr_valid0),
        .stall_signal(stall_signal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit    exp;
        int    cyc;
        string tag;
    } exp_t;

    typedef struct {
        int                cyc;
        logic [ADDR_W-1:0] addr;
    } wr_t;

    exp_t sb_q[$];
    wr_t  wr_log[$];
    int   cyc_cnt   = 0;
    int   last_rst  = -1;
    int   checks    = 0;
    int   errors    = 0;
    bit   stim_done = 0;

    function automatic bit same_addr(logic [ADDR_W-1:0] a, logic [ADDR_W-1:0] b);
`ifdef HDU_BANK_MATCH_EN
        return (a % (1 << Bank_Num_W)) == (b % (1 << Bank_Num_W));
`else
        return a == b;
`endif
    endfunction

    // One stimulus cycle: drive at the falling edge, predict the flag that appears after the next rising edge.
    task automatic drive(input bit r, input bit rv, input int ra, input bit wv, input int wa,
                         input string tag);
        exp_t e;
        wr_t  w;
        bit   hit;
        @(negedge clk);
        rst          = r;
        Raddr_valid0 = rv;
        Raddr0       = ADDR_W'(ra);
        Waddr_valid0 = wv;
        Waddr0       = ADDR_W'(wa);
        hit = 1'b0;
        if (!r) begin
            last_rst = cyc_cnt;
            wr_log.delete();
        end else begin
            if (wv) begin
                w.cyc  = cyc_cnt;
                w.addr = ADDR_W'(wa);
                wr_log.push_back(w);
            end
            while (wr_log.size() > 0 && cyc_cnt - wr_log[0].cyc > HAZ_DEPTH)
                void'(wr_log.pop_front());
            if (rv) begin
                foreach (wr_log[k]) begin
                    if (wr_log[k].cyc > last_rst && same_addr(wr_log[k].addr, ADDR_W'(ra)))
                        hit = 1'b1;
                end
            end
        end
        e.exp = hit;
        e.cyc = cyc_cnt;
        e.tag = tag;
        sb_q.push_back(e);
        cyc_cnt++;
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, tag);
    endtask

    // Monitor: the flag is presented every cycle, so pop one expectation per rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (stall_signal !== e.exp) begin
                    errors++;
                    $display("FAIL %s cyc=%0d stall_signal=%0b expected=%0b", e.tag, e.cyc,
                             stall_signal, e.exp);
                end else begin
                    $display("txn %s cyc=%0d stall_signal=%0b", e.tag, e.cyc, stall_signal);
                end
            end
        end
    end

    initial begin
        rst = 0; Raddr0 = '0; Waddr0 = '0; Raddr_valid0 = 0; Waddr_valid0 = 0;

        for (int i = 0; i < 3; i++) drive(0, 1, 7, 1, 7, "reset_hold");
        drive(1, 1, 7, 0, 0, "post_reset_clear");

        drive(1, 1, 10, 1, 5, "no_hazard_a");
        drive(1, 1, 10, 1, 6, "no_hazard_b");

        drive(1, 1, 7, 1, 7, "same_cycle_hit");
        drive(1, 1, 1, 1, 2, "same_cycle_drop");
        idle(5, "flush");

        drive(1, 0, 0, 1, 20, "win_write");
        idle(3, "win_gap");
        drive(1, 1, 20, 0, 0, "win_edge_hit");
        idle(5, "flush");
        drive(1, 0, 0, 1, 20, "win_write2");
        idle(4, "win_gap2");
        drive(1, 1, 20, 0, 0, "win_past_edge");
        idle(5, "flush");

        drive(1, 0, 0, 0, 30, "inv_write");
        drive(1, 1, 30, 0, 0, "read_after_inv_write");
        drive(1, 0, 0, 1, 30, "valid_write");
        drive(1, 0, 30, 0, 0, "inv_read");
        idle(5, "flush");

        drive(1, 0, 0, 1, 50, "pre_reset_write");
        drive(0, 1, 50, 1, 50, "mid_reset");
        drive(1, 1, 50, 0, 0, "read_after_reset");
        drive(1, 0, 0, 1, 60, "dup_write_a");
        drive(1, 0, 0, 1, 60, "dup_write_b");
        idle(3, "dup_gap");
        drive(1, 1, 60, 0, 0, "dup_second_covers");
        idle(5, "flush");

        drive(1, 0, 0, 1, 'h0021, "bank_write");
        drive(1, 1, 'h0041, 0, 0, "bank_read");
        idle(5, "flush");

        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 24) != 0), $urandom_range(0, 1),
                  (($urandom_range(0, 3) == 0) ? 'h20 : 0) + $urandom_range(0, 7),
                  $urandom_range(0, 1),
                  (($urandom_range(0, 3) == 0) ? 'h40 : 0) + $urandom_range(0, 7), "random");
        end
        idle(2, "drain");
        stim_done = 1;
    end

    initial begin
        int budget;
        wait (stim_done);
        budget = 0;
        while (sb_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #2;
        if (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d expected=0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached=1 expected=0");
        $fatal(1, "timeout");
    end

endmodule
